// File: rtl/video_timing_measure.sv
// -----------------------------------------------------------------------------
// video_timing_measure
//
// Measures active video geometry from pre-edge-detected sync pulses and a data
// enable. It counts pixels per line and lines per frame, and reports the
// geometry of the last closed frame. It locks once two consecutive frames
// measure the same non-zero geometry. It also reports a per-pixel coordinate
// stream.
//
// Ports
//   clk          single clock for all logic
//   rst_n        asynchronous active-low reset
//   enable       measurement enable; low forces IDLE on the next cycle
//   vs_pos       one-cycle vsync rising-edge pulse (frame close)
//   hs_pos       one-cycle hsync rising-edge pulse (line boundary)
//   de           data enable, aligned with the sync pulses
//   pix_valid    de delayed one cycle (outside IDLE)
//   pix_x/pix_y  column/row of the pixel qualified by pix_valid
//   h_active     active pixels per line of the last closed frame
//   v_active     active lines of the last closed frame
//   frame_start  one-cycle pulse the cycle after an accepted vs_pos
//   locked       geometry stable over consecutive frames
//   err          one-cycle pulse on a geometry change while locked
//   dbg_state    current FSM state encoding, for observation only
//
// Output qualification: pix_valid is a pure valid strobe with no ready. When
// it is high, pix_x/pix_y carry that pixel for exactly one cycle. When it is
// low, pix_x/pix_y hold their last value. There is no backpressure.
// -----------------------------------------------------------------------------
module video_timing_measure #(
   parameter int CW = 12
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          enable,
   input  logic          vs_pos,
   input  logic          hs_pos,
   input  logic          de,
   output logic          pix_valid,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic [CW-1:0] h_active,
   output logic [CW-1:0] v_active,
   output logic          frame_start,
   output logic          locked,
   output logic          err,
   output logic [2:0]    dbg_state
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_SEEK    = 3'd1,
      S_MEASURE = 3'd2,
      S_CHECK   = 3'd3,
      S_LOCKED  = 3'd4
   } state_t;

   localparam logic [CW-1:0] CNT_MAX = '1;

   function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
      return (v == CNT_MAX) ? v : v + CW'(1);
   endfunction

   state_t        state, state_nxt;
   logic [CW-1:0] px, ln, last_h;
   logic [CW-1:0] ref_h, ref_v;

   // Stage 1: line boundary (hs_pos).
   logic [CW-1:0] px1, ln1, lh1;
   // Stage 2: frame close (vs_pos), after any same-cycle line boundary.
   logic [CW-1:0] px2, ln2, lh2;
   logic [CW-1:0] meas_h, meas_v;
   logic [CW-1:0] px_nxt;
   logic          geom_match;
   logic          run;

   logic          store_ref, load_active, err_nxt, fs_nxt;

   // Counters only run while enabled and out of IDLE. In IDLE they are held
   // clear, so anything seen there is ignored.
   assign run = enable && (state != S_IDLE);

   always_comb begin
      px1 = px;
      ln1 = ln;
      lh1 = last_h;
      if (hs_pos) begin
         if (px != '0) begin
            ln1 = sat_inc(ln);
            lh1 = px;
         end
         px1 = '0;
      end

      // A line still open at vsync counts as a full line of the frame.
      meas_h = lh1;
      meas_v = ln1;
      if (px1 != '0) begin
         meas_h = px1;
         meas_v = sat_inc(ln1);
      end

      px2 = px1;
      ln2 = ln1;
      lh2 = lh1;
      if (vs_pos) begin
         px2 = '0;
         ln2 = '0;
         lh2 = '0;
      end

      // A de on a boundary cycle is pixel 0 of the new line or frame.
      px_nxt = de ? sat_inc(px2) : px2;
   end

   assign geom_match = (meas_h == ref_h) && (meas_v == ref_v) &&
                       (meas_h != '0) && (meas_v != '0);

   always_comb begin
      state_nxt   = state;
      store_ref   = 1'b0;
      load_active = 1'b0;
      err_nxt     = 1'b0;
      fs_nxt      = 1'b0;
      if (!enable) begin
         state_nxt = S_IDLE;
      end else begin
         case (state)
            S_IDLE: state_nxt = S_SEEK;
            S_SEEK: begin
               if (vs_pos) begin
                  state_nxt = S_MEASURE;
                  fs_nxt    = 1'b1;
               end
            end
            S_MEASURE: begin
               if (vs_pos) begin
                  state_nxt   = S_CHECK;
                  fs_nxt      = 1'b1;
                  store_ref   = 1'b1;
                  load_active = 1'b1;
               end
            end
            S_CHECK: begin
               if (vs_pos) begin
                  fs_nxt      = 1'b1;
                  load_active = 1'b1;
                  if (geom_match) begin
                     state_nxt = S_LOCKED;
                  end else begin
                     store_ref = 1'b1;
                  end
               end
            end
            S_LOCKED: begin
               if (vs_pos) begin
                  fs_nxt      = 1'b1;
                  load_active = 1'b1;
                  if (!geom_match) begin
                     state_nxt = S_CHECK;
                     err_nxt   = 1'b1;
                     store_ref = 1'b1;
                  end
               end
            end
            default: state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         px          <= '0;
         ln          <= '0;
         last_h      <= '0;
         ref_h       <= '0;
         ref_v       <= '0;
         pix_valid   <= 1'b0;
         pix_x       <= '0;
         pix_y       <= '0;
         h_active    <= '0;
         v_active    <= '0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         err         <= 1'b0;
      end else begin
         state       <= state_nxt;
         locked      <= (state_nxt == S_LOCKED);
         err         <= err_nxt;
         frame_start <= fs_nxt;
         pix_valid   <= run && de;
         if (run) begin
            px     <= px_nxt;
            ln     <= ln2;
            last_h <= lh2;
            if (de) begin
               pix_x <= px2;
               pix_y <= ln2;
            end
         end else begin
            px     <= '0;
            ln     <= '0;
            last_h <= '0;
            ref_h  <= '0;
            ref_v  <= '0;
         end
         if (run && store_ref) begin
            ref_h <= meas_h;
            ref_v <= meas_v;
         end
         if (run && load_active) begin
            h_active <= meas_h;
            v_active <= meas_v;
         end
      end
   end

   assign dbg_state = state;

endmodule

// File: tb/tb_video_timing_measure.sv
// -----------------------------------------------------------------------------
// tb_video_timing_measure
//
// Directed bench for video_timing_measure. A CW=12 instance carries the main
// checks. A CW=4 instance shares the same stimulus and is checked for counter
// saturation.
// -----------------------------------------------------------------------------
module tb_video_timing_measure;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        vs_pos;
   logic        hs_pos;
   logic        de;

   logic        w_pix_valid, w_frame_start, w_locked, w_err;
   logic [11:0] w_pix_x, w_pix_y, w_h_active, w_v_active;
   logic [2:0]  w_dbg_state;

   logic        n_pix_valid, n_frame_start, n_locked, n_err;
   logic [3:0]  n_pix_x, n_pix_y, n_h_active, n_v_active;
   logic [2:0]  n_dbg_state;

   int total = 0;
   int bad   = 0;

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   video_timing_measure #(.CW(12)) dut_w (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .vs_pos(vs_pos), .hs_pos(hs_pos), .de(de),
      .pix_valid(w_pix_valid), .pix_x(w_pix_x), .pix_y(w_pix_y),
      .h_active(w_h_active), .v_active(w_v_active),
      .frame_start(w_frame_start), .locked(w_locked), .err(w_err),
      .dbg_state(w_dbg_state)
   );

   video_timing_measure #(.CW(4)) dut_n (
      .clk(clk), .rst_n(rst_n), .enable(enable),
      .vs_pos(vs_pos), .hs_pos(hs_pos), .de(de),
      .pix_valid(n_pix_valid), .pix_x(n_pix_x), .pix_y(n_pix_y),
      .h_active(n_h_active), .v_active(n_v_active),
      .frame_start(n_frame_start), .locked(n_locked), .err(n_err),
      .dbg_state(n_dbg_state)
   );

   // ---------------- checker ----------------
   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // ---------------- drivers ----------------
   // Apply one cycle of inputs. Return 1 time unit after the edge, where the
   // registered outputs produced by that cycle are stable.
   task automatic step(input logic v, input logic h, input logic d);
      vs_pos = v;
      hs_pos = h;
      de     = d;
      @(posedge clk);
      #1;
      vs_pos = 1'b0;
      hs_pos = 1'b0;
      de     = 1'b0;
   endtask

   task automatic line(input int width);
      step(1'b0, 1'b1, 1'b0);
      repeat (width) step(1'b0, 1'b0, 1'b1);
      step(1'b0, 1'b0, 1'b0);
   endtask

   task automatic frame(input int lines, input int width);
      repeat (lines) line(width);
   endtask

   task automatic vsync();
      step(1'b1, 1'b0, 1'b0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      rst_n  = 1'b0;
      enable = 1'b0;
      vs_pos = 1'b0;
      hs_pos = 1'b0;
      de     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pix_valid",   w_pix_valid,   0);
      check("rst_pix_x",       w_pix_x,       0);
      check("rst_h_active",    w_h_active,    0);
      check("rst_v_active",    w_v_active,    0);
      check("rst_frame_start", w_frame_start, 0);
      check("rst_locked",      w_locked,      0);
      check("rst_err",         w_err,         0);
      check("rst_state",       w_dbg_state,   0);
      @(negedge clk);
      rst_n = 1'b1;

      // Disabled: all inputs are ignored.
      step(1'b1, 1'b1, 1'b1);
      check("idle_frame_start", w_frame_start, 0);
      check("idle_pix_valid",   w_pix_valid,   0);
      check("idle_state",       w_dbg_state,   0);

      // Enable, feed a partial frame, then take the first vsync in SEEK.
      enable = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      check("seek_state", w_dbg_state, 1);
      frame(2, 5);
      vsync();
      check("vs1_frame_start", w_frame_start, 1);
      check("vs1_no_load_h",   w_h_active,    0);
      check("vs1_locked",      w_locked,      0);
      step(1'b0, 1'b0, 1'b0);
      check("vs1_fs_oneshot",  w_frame_start, 0);

      // Frame 1: 4 lines x 8, with pixel coordinates probed on line 1.
      line(8);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      check("f1_pix_valid", w_pix_valid, 1);
      check("f1_pix_x0",    w_pix_x,     0);
      check("f1_pix_y1",    w_pix_y,     1);
      step(1'b0, 1'b0, 1'b1);
      check("f1_pix_x1",    w_pix_x,     1);
      repeat (6) step(1'b0, 1'b0, 1'b1);
      check("f1_pix_x7",    w_pix_x,     7);
      step(1'b0, 1'b0, 1'b0);
      check("f1_valid_low", w_pix_valid, 0);
      check("f1_x_hold",    w_pix_x,     7);
      frame(2, 8);
      vsync();
      check("vs2_h_active", w_h_active,    8);
      check("vs2_v_active", w_v_active,    4);
      check("vs2_fs",       w_frame_start, 1);
      check("vs2_locked",   w_locked,      0);

      // Frame 2: de coincident with hsync at the start of line 1.
      line(8);
      step(1'b0, 1'b1, 1'b1);
      check("coin_pix_x", w_pix_x, 0);
      check("coin_pix_y", w_pix_y, 1);
      repeat (7) step(1'b0, 1'b0, 1'b1);
      check("coin_pix_x7", w_pix_x, 7);
      step(1'b0, 1'b0, 1'b0);
      frame(2, 8);
      check("f2_not_locked", w_locked, 0);
      vsync();
      check("vs3_locked",   w_locked,   1);
      check("vs3_h_active", w_h_active, 8);
      check("vs3_v_active", w_v_active, 4);
      check("vs3_err",      w_err,      0);

      // Frame 3: same geometry, stays locked.
      frame(4, 8);
      vsync();
      check("f3_locked", w_locked, 1);
      check("f3_err",    w_err,    0);

      // Frame 4: 5 lines while locked -> error pulse, drop lock.
      frame(5, 8);
      vsync();
      check("f4_err",      w_err,      1);
      check("f4_locked",   w_locked,   0);
      check("f4_v_active", w_v_active, 5);
      check("f4_h_active", w_h_active, 8);
      step(1'b0, 1'b0, 1'b0);
      check("f4_err_oneshot", w_err, 0);

      // Frames 5 and 6: 5x8 again, relock.
      frame(5, 8);
      vsync();
      check("f5_locked", w_locked, 1);
      check("f5_err",    w_err,    0);
      frame(5, 8);
      vsync();
      check("f6_locked", w_locked, 1);

      // Frame 7: last line closed by hsync before vsync, same geometry.
      frame(5, 8);
      step(1'b0, 1'b1, 1'b0);
      vsync();
      check("f7_v_active", w_v_active, 5);
      check("f7_locked",   w_locked,   1);
      check("f7_err",      w_err,      0);

      // Disable mid-frame with a mismatching vsync in the same cycle.
      frame(2, 8);
      enable = 1'b0;
      step(1'b1, 1'b0, 1'b0);
      check("dis_locked", w_locked,      0);
      check("dis_err",    w_err,         0);
      check("dis_fs",     w_frame_start, 0);
      check("dis_state",  w_dbg_state,   0);
      step(1'b0, 1'b0, 1'b1);
      check("dis_pix_valid", w_pix_valid, 0);

      // Relock requires three vsyncs.
      enable = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      vsync();
      check("re_vs1_locked", w_locked, 0);
      frame(4, 8);
      vsync();
      check("re_vs2_locked", w_locked, 0);
      frame(4, 8);
      vsync();
      check("re_vs3_locked", w_locked,   1);
      check("re_v_active",   w_v_active, 4);

      // Asynchronous reset mid-frame while locked.
      frame(2, 8);
      step(1'b0, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1);
      rst_n = 1'b0;
      #2;
      check("arst_locked",    w_locked,    0);
      check("arst_h_active",  w_h_active,  0);
      check("arst_v_active",  w_v_active,  0);
      check("arst_pix_valid", w_pix_valid, 0);
      check("arst_pix_x",     w_pix_x,     0);
      check("arst_state",     w_dbg_state, 0);
      step(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b0, 1'b0, 1'b0);
      frame(1, 8);
      vsync();
      check("rr_vs1_locked", w_locked,   0);
      check("rr_vs1_h",      w_h_active, 0);
      frame(4, 8);
      vsync();
      check("rr_vs2_locked", w_locked,   0);
      check("rr_vs2_h",      w_h_active, 8);
      frame(4, 8);
      vsync();
      check("rr_vs3_locked", w_locked, 1);

      // 20-pixel lines: the CW=4 instance saturates at 15.
      step(1'b0, 1'b1, 1'b0);
      repeat (16) step(1'b0, 1'b0, 1'b1);
      check("sat_n_pix_x16", n_pix_x, 15);
      check("sat_w_pix_x16", w_pix_x, 15);
      repeat (4) step(1'b0, 1'b0, 1'b1);
      check("sat_n_pix_x20", n_pix_x, 15);
      check("sat_w_pix_x20", w_pix_x, 19);
      step(1'b0, 1'b0, 1'b0);
      frame(3, 20);
      vsync();
      check("sat_n_h_active", n_h_active, 15);
      check("sat_n_v_active", n_v_active, 4);
      check("sat_w_h_active", w_h_active, 20);
      check("sat_w_err",      w_err,      1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
